// File: rtl/alu0_issue_wb_pkg.sv
// Shared functional-unit definitions for the ALU0 issue/writeback block.
// Holds the 4-bit ALU minor opcode encoding and the result FIFO depth.
package alu0_issue_wb_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'h0,
        OP_INC     = 4'h1,
        OP_SUB     = 4'h2,
        OP_DEC     = 4'h3,
        OP_AND     = 4'h4,
        OP_XOR     = 4'h5,
        OP_OR      = 4'h6,
        OP_MOVE    = 4'h7,
        OP_CARRY   = 4'h8,
        OP_ADD_OVF = 4'h9,
        OP_BORROW  = 4'hA,
        OP_SUB_OVF = 4'hB,
        OP_NAND    = 4'hC,
        OP_XNOR    = 4'hD,
        OP_NOR     = 4'hE,
        OP_NOT_B   = 4'hF
    } minor_op_e;

    // Result FIFO depth; sized to match the 2-bit occupancy counter.
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage

// File: rtl/alu0_issue_wb_simplealu0.sv
// SimpleALU0: purely combinational ALU for the ALU0 issue slot.
// Ports:
//   MinorOpcode - 4-bit minor opcode (see alu0_issue_wb_pkg::minor_op_e)
//   OperandA/B  - DATABITWIDTH-bit operands
//   Result      - DATABITWIDTH-bit result
// Unary ops (inc/dec/move/NOT) act on operand B. Flag ops (carry, add
// overflow, borrow, sub overflow) return the flag zero-extended to full width.
module SimpleALU0
    import alu0_issue_wb_pkg::*;
#(
    parameter int DATABITWIDTH = 16
) (
    input  logic [3:0]              MinorOpcode,
    input  logic [DATABITWIDTH-1:0] OperandA,
    input  logic [DATABITWIDTH-1:0] OperandB,
    output logic [DATABITWIDTH-1:0] Result
);

    localparam int W = DATABITWIDTH;

    logic [W:0]   sum_ext;
    logic [W:0]   diff_ext;
    logic         add_ovf;
    logic         sub_ovf;
    logic [W-1:0] one;

    always_comb begin
        one      = {{(W-1){1'b0}}, 1'b1};
        sum_ext  = {1'b0, OperandA} + {1'b0, OperandB};
        // MSB of the extended difference is the unsigned borrow.
        diff_ext = {1'b0, OperandA} - {1'b0, OperandB};
        // Signed overflow: operands agree in sign (add) / differ (sub) and the
        // result sign differs from A.
        add_ovf  = (OperandA[W-1] == OperandB[W-1]) && (sum_ext[W-1]  != OperandA[W-1]);
        sub_ovf  = (OperandA[W-1] != OperandB[W-1]) && (diff_ext[W-1] != OperandA[W-1]);
    end

    always_comb begin
        Result = '0;
        case (MinorOpcode)
            OP_ADD:     Result = sum_ext[W-1:0];
            OP_INC:     Result = OperandB + one;
            OP_SUB:     Result = diff_ext[W-1:0];
            OP_DEC:     Result = OperandB - one;
            OP_AND:     Result = OperandA & OperandB;
            OP_XOR:     Result = OperandA ^ OperandB;
            OP_OR:      Result = OperandA | OperandB;
            OP_MOVE:    Result = OperandB;
            OP_CARRY:   Result = {{(W-1){1'b0}}, sum_ext[W]};
            OP_ADD_OVF: Result = {{(W-1){1'b0}}, add_ovf};
            OP_BORROW:  Result = {{(W-1){1'b0}}, diff_ext[W]};
            OP_SUB_OVF: Result = {{(W-1){1'b0}}, sub_ovf};
            OP_NAND:    Result = ~(OperandA & OperandB);
            OP_XNOR:    Result = ~(OperandA ^ OperandB);
            OP_NOR:     Result = ~(OperandA | OperandB);
            OP_NOT_B:   Result = ~OperandB;
            default:    Result = '0;
        endcase
    end

endmodule

// File: rtl/alu0_issue_wb.sv
// alu0_issue_wb: ALU0 functional unit with a 2-entry writeback result FIFO.
// Ports:
//   clk, clear               - clock, synchronous active-high reset
//   IssueValid/IssueReady    - issue handshake (push when both high)
//   IssueMinorOpcode         - ALU op select
//   IssueOperandA/B          - operands
//   IssueDestReg             - writeback register tag
//   WBValid/WBAck            - writeback handshake (pop when both high)
//   WBDestReg/WBData         - head entry; forced to 0 while WBValid is low
// The result is computed at issue and stored, so writeback latency is 1 cycle.
module alu0_issue_wb
    import alu0_issue_wb_pkg::*;
#(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       IssueValid,
    output logic                       IssueReady,
    input  logic [3:0]                 IssueMinorOpcode,
    input  logic [DATABITWIDTH-1:0]    IssueOperandA,
    input  logic [DATABITWIDTH-1:0]    IssueOperandB,
    input  logic [REGADDRBITWIDTH-1:0] IssueDestReg,
    output logic                       WBValid,
    input  logic                       WBAck,
    output logic [REGADDRBITWIDTH-1:0] WBDestReg,
    output logic [DATABITWIDTH-1:0]    WBData
);

    logic [DATABITWIDTH-1:0]    alu_result;

    logic [DATABITWIDTH-1:0]    data_q [2];
    logic [DATABITWIDTH-1:0]    data_d [2];
    logic [REGADDRBITWIDTH-1:0] tag_q  [2];
    logic [REGADDRBITWIDTH-1:0] tag_d  [2];
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic [1:0]                 count_q,  count_d;
    logic                       push;
    logic                       pop;

    SimpleALU0 #(
        .DATABITWIDTH (DATABITWIDTH)
    ) u_alu (
        .MinorOpcode (IssueMinorOpcode),
        .OperandA    (IssueOperandA),
        .OperandB    (IssueOperandB),
        .Result      (alu_result)
    );

    // Ready depends only on occupancy: a full FIFO never accepts, even if the
    // head is being acknowledged this cycle.
    assign IssueReady = (count_q < FIFO_DEPTH);
    assign WBValid    = (count_q != 2'd0);
    assign WBData     = WBValid ? data_q[rd_ptr_q] : '0;
    assign WBDestReg  = WBValid ? tag_q[rd_ptr_q]  : '0;

    assign push = IssueValid & IssueReady;
    assign pop  = WBValid & WBAck;

    always_comb begin
        data_d   = data_q;
        tag_d    = tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            data_d[wr_ptr_q] = alu_result;
            tag_d[wr_ptr_q]  = IssueDestReg;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            data_q    <= data_d;
            tag_q     <= tag_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule
